// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state, queue entry layout and PC step helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Next sequential word address; wraps naturally at 2^32.
    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue holding {instr, pc} entries between instruction memory and decode.
// Latency: an entry pushed at an edge is presented at the head after that edge.
// Backpressure: the caller guarantees space before pushing; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,        // rising-edge clock
    input  logic                   rst_n,      // synchronous, active-low
    input  logic                   push,       // enqueue push_entry
    input  entry_t                 push_entry,
    input  logic                   pop,        // dequeue the head
    input  logic                   flush,      // discard everything queued
    output entry_t                 head,       // oldest entry
    output logic [$clog2(DEPTH):0] count       // occupancy
);
    logic [$bits(entry_t)-1:0] head_raw;

    fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_vld  (pop),
        .flush    (flush),
        .head_dat (head_raw),
        .count    (count)
    );

    assign head = entry_t'(head_raw);

endmodule

// File: rtl/fifo.sv
// Generic synchronous FIFO with flush; the head word is read straight from storage.
// Latency: a word pushed at an edge is visible at the head after that edge.
// Backpressure: pop when empty and push when full (without a same-cycle pop) are ignored; flush wins.
module fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,       // rising-edge clock
    input  logic                   rst_n,     // synchronous, active-low
    input  logic                   push_vld,  // write push_dat this cycle
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_vld,   // retire the head this cycle
    input  logic                   flush,     // empty the FIFO, overrides push/pop
    output logic [WIDTH-1:0]       head_dat,  // oldest entry, meaningful when count != 0
    output logic [$clog2(DEPTH):0] count      // current occupancy
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok   = pop_vld && (count != '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign push_ok  = push_vld && ((count < (AW + 1)'(DEPTH)) || pop_ok);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, requests words from imem, queues them for decode.
// Latency: reset release -> imem_req next edge; imem_ack edge -> out_valid after that edge.
// Backpressure: stops requesting when the queue would be full; redirects flush and drop stale data.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,            // rising-edge clock
    input  logic        rst_n,          // synchronous, active-low
    output logic        imem_req,       // request outstanding, held until ack
    output logic [31:0] imem_addr,      // word address of the request
    input  logic        imem_ack,       // imem_rdata valid for the current request
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid, // taken branch, one-cycle pulse
    input  logic [31:0] redirect_pc,    // branch target, low bits ignored
    output logic        out_valid,      // queue head valid
    input  logic        out_ready,      // decode takes the head
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [31:0]   fpc;
    logic [31:0]   redirect_aligned;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          space;
    entry_t        push_entry;
    entry_t        head;

    assign redirect_aligned = redirect_pc & ~32'h3;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // Only data for a live request is kept; a redirect in the same cycle discards it.
    assign push      = (state == REQ) && imem_ack && !redirect_valid;

    assign push_entry = '{instr: imem_rdata, pc: fpc};

    // Occupancy after this cycle decides whether another request may be in flight.
    always_comb begin
        count_next = count;
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            if (push) count_next = count_next + CW'(1);
            if (pop)  count_next = count_next - CW'(1);
        end
    end

    assign space = (count_next < CW'(DEPTH));

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = next_word(head.pc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            if (redirect_valid) fpc <= redirect_aligned;

            unique case (state)
                IDLE: begin
                    // A redirect here only moves fpc; issue on the following cycle.
                    if (!redirect_valid && space) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fpc;
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            // Request must still complete; its data will be thrown away.
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        fpc <= next_word(fpc);
                        if (space) begin
                            imem_addr <= next_word(fpc);
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end

                DROP: begin
                    // Address and req stay put until the stale word arrives.
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table on streaming/wrap, scoreboard on delivered instructions.
// Latency: n/a.
// Backpressure: exercised through out_ready and a variable-latency memory responder.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    // Second instance with a reset PC just below the wrap point.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pl4;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .out_valid(w_valid), .out_ready(w_ready), .out_instr(w_instr),
        .out_pc(w_pc), .out_pc_plus4(w_pl4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: returns the address as data after 'lat' wait cycles.
    int   lat = 0;
    int   wait_cnt = 0;
    logic stray_ack;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    assign imem_ack   = (imem_req && (wait_cnt >= lat)) || stray_ack;
    assign imem_rdata = stray_ack ? 32'hDEAD_BEEF : imem_addr;
    assign w_ack      = w_req;
    assign w_rdata    = w_addr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b required %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected PCs in delivery order; memory data equals the PC.
    logic        sb_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    always @(negedge clk) begin
        if (sb_en && rst_n && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra actual pc %h required no output", out_pc);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_pc", out_pc, sb_exp);
                check("sb_instr", out_instr, sb_exp);
                check("sb_pc_plus4", out_pc_plus4, sb_exp + 32'd4);
            end
        end
    end

    task automatic reset_dut(input int l, input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        stray_ack      = 1'b0;
        out_ready      = rdy;
        lat            = l;
        step();
        step();
        exp_q.delete();
        check1("reset_req", imem_req, 1'b0);
        check1("reset_valid", out_valid, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic drain_sb(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
        out_ready = 1'b0;
        step();
        sb_en = 1'b0;
    endtask

    typedef struct {
        logic        rst_n;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] w_addr;
        logic [31:0] w_pc;
        logic [31:0] w_pl4;
    } vec_t;

    vec_t tbl [7];
    int   n;
    int   pushes;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0,          32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0,          32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h4, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h8, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'hC, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h10, 32'h0000_000C, 32'h0000_0008, 32'h0000_000C};

        rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        stray_ack = 1'b0; w_redir = 1'b0; w_redir_pc = '0; w_ready = 1'b1;

        // Streaming from reset, zero-wait memory, both instances.
        for (int i = 0; i < 7; i++) begin
            rst_n     = tbl[i].rst_n;
            out_ready = 1'b1;
            if (i == 1) begin
                sb_en = 1'b1;
                for (int j = 0; j < 8; j++) exp_q.push_back(32'(4 * j));
            end
            step();
            check1("tbl_req", imem_req, tbl[i].req);
            check("tbl_addr", imem_addr, tbl[i].addr);
            check1("tbl_valid", out_valid, tbl[i].vld);
            check("w_addr", w_addr, tbl[i].w_addr);
            check1("w_req", w_req, tbl[i].req);
            check1("w_valid", w_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                check("tbl_pc", out_pc, tbl[i].pc);
                check("tbl_instr", out_instr, tbl[i].pc);
                check("tbl_pc_plus4", out_pc_plus4, tbl[i].pc + 32'd4);
                check("w_pc", w_pc, tbl[i].w_pc);
                check("w_pc_plus4", w_pl4, tbl[i].w_pl4);
            end
        end
        out_ready = 1'b0;
        step();
        sb_en = 1'b0;
        exp_q.delete();

        // Backpressure: queue fills with exactly DEPTH words, then fetch stops.
        reset_dut(0, 1'b0);
        sb_en = 1'b1;
        for (int j = 0; j < 8; j++) exp_q.push_back(32'(4 * j));
        pushes = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (imem_req && imem_ack) pushes++;
        end
        check("bp_pushes", pushes, 4);
        check1("bp_req_low", imem_req, 1'b0);
        check1("bp_valid", out_valid, 1'b1);
        check("bp_head", out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        check1("bp_resume_req", imem_req, 1'b1);
        check("bp_resume_addr", imem_addr, 32'h10);
        drain_sb("bp_drain");

        // Redirect while waiting on a slow memory: request held, its data dropped.
        reset_dut(3, 1'b1);
        sb_en = 1'b1;
        exp_q.push_back(32'h0);
        n = 0;
        while (!(imem_req && imem_addr == 32'h8) && n < 40) begin step(); n++; end
        check("slow_reach_addr8", imem_addr, 32'h8);
        check1("slow_no_ack_yet", imem_ack, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check1("slow_flush_valid", out_valid, 1'b0);
        n = 0;
        while (!imem_ack && n < 20) begin
            check1("drop_req", imem_req, 1'b1);
            check("drop_addr", imem_addr, 32'h8);
            check1("drop_valid", out_valid, 1'b0);
            step();
            n++;
        end
        check1("drop_ack_seen", imem_ack, 1'b1);
        step();
        check1("drop_idle_req", imem_req, 1'b0);
        check1("drop_idle_valid", out_valid, 1'b0);
        step();
        check1("redir_req", imem_req, 1'b1);
        check("redir_addr", imem_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        drain_sb("slow_drain");

        // Redirect coinciding with ack and pop; target low bits are masked.
        reset_dut(0, 1'b1);
        sb_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        n = 0;
        while (!(imem_req && imem_addr == 32'hC) && n < 20) begin step(); n++; end
        check("same_reach_addr", imem_addr, 32'hC);
        check1("same_ack", imem_ack, 1'b1);
        check1("same_pop_valid", out_valid, 1'b1);
        check("same_head", out_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        check1("same_flush_valid", out_valid, 1'b0);
        check1("same_idle_req", imem_req, 1'b0);
        step();
        check1("same_reissue_req", imem_req, 1'b1);
        check("same_reissue_addr", imem_addr, 32'h200);
        check1("same_still_empty", out_valid, 1'b0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        drain_sb("same_drain");

        // Reset while in DROP with an ack pending, then a stray ack in IDLE.
        reset_dut(3, 1'b1);
        sb_en = 1'b1;
        n = 0;
        while (!(imem_req && imem_addr == 32'h4) && n < 40) begin step(); n++; end
        check("rst_reach_addr4", imem_addr, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check1("rst_drop_req", imem_req, 1'b1);
        check1("rst_drop_pending", imem_ack, 1'b0);
        rst_n = 1'b0;
        step();
        check1("rst_mid_req", imem_req, 1'b0);
        check1("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_addr", imem_addr, 32'h0);
        rst_n     = 1'b1;
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        check1("stray_valid", out_valid, 1'b0);
        check1("stray_req", imem_req, 1'b1);
        check("stray_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain_sb("rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
